// File: rtl/mem_pkg.sv
// Shared memory-port codes, loader defaults and the loader FSM state type.
package mem_pkg;

   // Access-size codes understood by the memory port
   localparam logic [1:0] ACC_1W  = 2'b00;
   localparam logic [1:0] ACC_4W  = 2'b01;
   localparam logic [1:0] ACC_8W  = 2'b10;
   localparam logic [1:0] ACC_16W = 2'b11;

   // Direction encoding of mem_rw
   localparam logic MEM_RW_WRITE = 1'b0;
   localparam logic MEM_RW_READ  = 1'b1;

   // Byte address where the program image is placed by default
   localparam logic [31:0] DEFAULT_START_ADDR = 32'h8002_0000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_BURST   = 3'd2,
      ST_TAIL    = 3'd3,
      ST_DONE    = 3'd4
   } loader_state_e;

   // Number of words moved by one access of the given size code
   function automatic logic [4:0] acc_words(input logic [1:0] code);
      logic [4:0] n;
      case (code)
         ACC_1W:  n = 5'd1;
         ACC_4W:  n = 5'd4;
         ACC_8W:  n = 5'd8;
         ACC_16W: n = 5'd16;
         default: n = 5'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/loader_fifo.sv
// Single-clock FIFO buffering program words ahead of the memory writer.
// Exposes the head word and the word behind it so a write beat can be
// followed by the next one without a bubble. DEPTH must be a power of 2.
module loader_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [WIDTH-1:0]         next_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_o    = (count_q == CNT_FULL);
   assign empty_o   = (count_q == CNT_ZERO);
   assign count_o   = count_q;
   assign head_o    = mem_q[rd_ptr_q];
   assign next_o    = mem_q[rd_ptr_q + PTR_ONE];
   // A push into a full FIFO is fine when a pop frees the slot in the same cycle
   assign pop_ok_s  = pop_i && !empty_o;
   assign push_ok_s = push_i && (!full_o || pop_ok_s);

   // Word storage; contents need no reset because count gates visibility
   always_ff @(posedge clock_i) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= CNT_ZERO;
      end else begin
         if (push_ok_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_loader.sv
// Write-side initiator that streams a program image into memory starting at
// START_ADDR, using bursts while enough words are buffered and single writes
// for the remainder, then hands the port to fetch by raising enable_fetch.
// During a burst mem_address holds the burst base; the memory steps through
// consecutive words itself while mem_data_in advances one word per beat.
module mem_loader
   import mem_pkg::*;
#(
   parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR,
   parameter logic [1:0]  BURST_SIZE = ACC_4W,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic [1:0]  mem_access_size,
   output logic        mem_rw,
   output logic        mem_enable,
   input  logic        mem_busy,
   output logic [31:0] words_written,
   output logic        done,
   output logic        enable_fetch
);

   localparam int unsigned CW          = $clog2(FIFO_DEPTH);
   localparam logic [4:0]  BURST_LEN   = acc_words(BURST_SIZE);
   localparam logic [4:0]  LAST_BEAT   = BURST_LEN - 5'd1;
   localparam logic [31:0] BURST_LEN_W = {27'd0, BURST_LEN};
   localparam logic [31:0] BURST_BYTES = {25'd0, BURST_LEN, 2'b00};

   loader_state_e state_q;
   logic [31:0]   base_q;
   logic [4:0]    beat_q;
   logic          last_seen_q;
   logic [31:0]   mem_address_q;
   logic [31:0]   mem_data_in_q;
   logic [1:0]    mem_access_size_q;
   logic          mem_rw_q;
   logic          mem_enable_q;
   logic [31:0]   words_written_q;
   logic          done_q;

   logic          push_s;
   logic          commit_s;
   logic          accepting_s;
   logic [31:0]   fifo_head_s;
   logic [31:0]   fifo_next_s;
   logic [CW:0]   fifo_count_s;
   logic [31:0]   fifo_count_w_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;

   // Input is open while a session runs and before the final word arrives
   assign accepting_s    = (state_q == ST_COLLECT) || (state_q == ST_BURST) ||
                           (state_q == ST_TAIL);
   assign in_ready       = accepting_s && !last_seen_q && !fifo_full_s;
   assign push_s         = in_valid && in_ready;
   // A presented beat is taken on any edge where memory is not stalling
   assign commit_s       = mem_enable_q && !mem_busy;
   assign fifo_count_w_s = 32'(fifo_count_s);

   assign mem_address     = mem_address_q;
   assign mem_data_in     = mem_data_in_q;
   assign mem_access_size = mem_access_size_q;
   assign mem_rw          = mem_rw_q;
   assign mem_enable      = mem_enable_q;
   assign words_written   = words_written_q;
   assign done            = done_q;
   assign enable_fetch    = done_q;

   loader_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clock_i (clock),
      .reset_i (reset),
      .push_i  (push_s),
      .pop_i   (commit_s),
      .data_i  (in_data),
      .head_o  (fifo_head_s),
      .next_o  (fifo_next_s),
      .count_o (fifo_count_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Session sequencing, write-beat generation and all registered port outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q           <= ST_IDLE;
         base_q            <= START_ADDR;
         beat_q            <= 5'd0;
         last_seen_q       <= 1'b0;
         mem_address_q     <= START_ADDR;
         mem_data_in_q     <= 32'd0;
         mem_access_size_q <= ACC_1W;
         mem_rw_q          <= MEM_RW_READ;
         mem_enable_q      <= 1'b0;
         words_written_q   <= 32'd0;
         done_q            <= 1'b0;
      end else begin
         if (push_s && in_last) begin
            last_seen_q <= 1'b1;
         end
         if (commit_s) begin
            words_written_q <= words_written_q + 32'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (fifo_count_w_s >= BURST_LEN_W) begin
                  state_q           <= ST_BURST;
                  beat_q            <= 5'd0;
                  mem_enable_q      <= 1'b1;
                  mem_rw_q          <= MEM_RW_WRITE;
                  mem_access_size_q <= BURST_SIZE;
                  mem_address_q     <= base_q;
                  mem_data_in_q     <= fifo_head_s;
               end else if (last_seen_q && !fifo_empty_s) begin
                  state_q           <= ST_TAIL;
                  mem_enable_q      <= 1'b1;
                  mem_rw_q          <= MEM_RW_WRITE;
                  mem_access_size_q <= ACC_1W;
                  mem_address_q     <= base_q;
                  mem_data_in_q     <= fifo_head_s;
               end else if (last_seen_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_BURST: begin
               if (commit_s) begin
                  if (beat_q == LAST_BEAT) begin
                     base_q            <= base_q + BURST_BYTES;
                     mem_enable_q      <= 1'b0;
                     mem_rw_q          <= MEM_RW_READ;
                     mem_access_size_q <= ACC_1W;
                     // Nothing left and no more input coming: finish right away
                     if (last_seen_q && (fifo_count_w_s == 32'd1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_COLLECT;
                     end
                  end else begin
                     beat_q        <= beat_q + 5'd1;
                     mem_data_in_q <= fifo_next_s;
                  end
               end
            end
            ST_TAIL: begin
               if (commit_s) begin
                  base_q <= base_q + 32'd4;
                  if (fifo_count_w_s > 32'd1) begin
                     mem_address_q <= base_q + 32'd4;
                     mem_data_in_q <= fifo_next_s;
                  end else begin
                     mem_enable_q      <= 1'b0;
                     mem_rw_q          <= MEM_RW_READ;
                     mem_access_size_q <= ACC_1W;
                     if (last_seen_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_COLLECT;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (start) begin
                  state_q         <= ST_COLLECT;
                  done_q          <= 1'b0;
                  words_written_q <= 32'd0;
                  last_seen_q     <= 1'b0;
                  base_q          <= START_ADDR;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: expected writes are queued as words are
// handed to the loader and matched against committed memory beats.
module tb_mem_loader;

   localparam logic [31:0] START   = 32'h8002_0000;
   localparam int          BURST_N = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_ready;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [1:0]  mem_access_size;
   logic        mem_rw;
   logic        mem_enable;
   logic        mem_busy;
   logic [31:0] words_written;
   logic        done;
   logic        enable_fetch;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          sess_k = 0;
   int          mon_beat = 0;
   int          mon_commits = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr;
   logic [31:0] prev_data;
   logic [1:0]  prev_size;

   mem_loader dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_last         (in_last),
      .in_ready        (in_ready),
      .mem_address     (mem_address),
      .mem_data_in     (mem_data_in),
      .mem_access_size (mem_access_size),
      .mem_rw          (mem_rw),
      .mem_enable      (mem_enable),
      .mem_busy        (mem_busy),
      .words_written   (words_written),
      .done            (done),
      .enable_fetch    (enable_fetch)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Memory-side monitor: stall stability and scoreboard match on each commit
   always @(negedge clock) begin : monitor
      exp_t        e;
      logic [31:0] a;
      if (reset) begin
         mon_beat   = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_addr", mem_address, prev_addr);
            check("stall_data", mem_data_in, prev_data);
            check("stall_enable", 32'(mem_enable), 32'd1);
            check("stall_size", 32'(mem_access_size), 32'(prev_size));
         end
         prev_stall = 1'b0;
         if (mem_enable === 1'b1 && mem_busy === 1'b1) begin
            prev_stall = 1'b1;
            prev_addr  = mem_address;
            prev_data  = mem_data_in;
            prev_size  = mem_access_size;
         end else if (mem_enable === 1'b1) begin
            mon_commits++;
            check("beat_rw", 32'(mem_rw), 32'd0);
            if (sb_q.size() == 0) begin
               check("unexpected_write_pending", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               if (mem_access_size == 2'b00) begin
                  a = mem_address;
               end else begin
                  a = mem_address + 32'(mon_beat) * 32'd4;
               end
               check("beat_addr", a, e.addr);
               check("beat_data", mem_data_in, e.data);
               check("beat_size", 32'(mem_access_size), 32'(e.size));
               if (mem_access_size != 2'b00) begin
                  mon_beat++;
                  if (mon_beat == BURST_N) begin
                     mon_beat = 0;
                  end
               end
            end
         end
      end
   end

   task automatic start_session();
      start = 1'b1;
      tick();
      start       = 1'b0;
      sess_k      = 0;
      mon_commits = 0;
   endtask

   // Offer one word, wait for the handshake and queue its expected write
   task automatic push_word(input logic [31:0] d, input logic last, input int total);
      exp_t e;
      int   waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && waited < 60) begin
         tick();
         waited++;
      end
      check("push_ready", 32'(in_ready), 32'd1);
      if (in_ready) begin
         e.addr = START + 32'(sess_k) * 32'd4;
         e.data = d;
         e.size = (sess_k < (total / BURST_N) * BURST_N) ? 2'b01 : 2'b00;
         sb_q.push_back(e);
         sess_k++;
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while (sb_q.size() != 0 && w < 200) begin
         tick();
         w++;
      end
      check("drain_pending", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_commits(input int n);
      int w = 0;
      while (mon_commits < n && w < 60) begin
         tick();
         w++;
      end
      check("commit_wait", 32'(mon_commits), 32'(n));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_addr"}, mem_address, START);
      check({tag, "_data"}, mem_data_in, 32'd0);
      check({tag, "_size"}, 32'(mem_access_size), 32'd0);
      check({tag, "_rw"}, 32'(mem_rw), 32'd1);
      check({tag, "_enable"}, 32'(mem_enable), 32'd0);
      check({tag, "_words"}, words_written, 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_fetch"}, 32'(enable_fetch), 32'd0);
   endtask

   task automatic check_finished(input string tag, input logic [31:0] n);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_fetch"}, 32'(enable_fetch), 32'd1);
      check({tag, "_words"}, words_written, n);
      check({tag, "_rw"}, 32'(mem_rw), 32'd1);
      check({tag, "_enable"}, 32'(mem_enable), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'd0;
      in_last  = 1'b0;
      mem_busy = 1'b0;
      repeat (2) tick();
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();

      // Eight words, no stall: two full bursts
      start_session();
      for (int i = 1; i <= 8; i++) push_word(32'(i), (i == 8), 8);
      drain();
      check_finished("two_bursts", 32'd8);

      // Restart from DONE, six words: one burst plus two single writes
      start_session();
      check("restart_done", 32'(done), 32'd0);
      check("restart_words", words_written, 32'd0);
      for (int i = 1; i <= 6; i++) push_word(32'h0000_0100 + 32'(i), (i == 6), 6);
      drain();
      check_finished("burst_tail", 32'd6);

      // Memory stalls three cycles on the third beat of the first burst
      start_session();
      for (int i = 1; i <= 4; i++) push_word(32'h0000_0200 + 32'(i), 1'b0, 8);
      wait_commits(2);
      mem_busy = 1'b1;
      repeat (3) tick();
      mem_busy = 1'b0;
      for (int i = 5; i <= 8; i++) push_word(32'h0000_0200 + 32'(i), (i == 8), 8);
      drain();
      check_finished("busy_beat", 32'd8);

      // Memory stalls while upstream offers 20 words into a 16-deep buffer
      start_session();
      mem_busy = 1'b1;
      for (int i = 1; i <= 16; i++) push_word(32'h0000_0300 + 32'(i), 1'b0, 20);
      check("full_in_ready", 32'(in_ready), 32'd0);
      repeat (2) tick();
      check("full_in_ready_hold", 32'(in_ready), 32'd0);
      check("full_no_commit", words_written, 32'd0);
      check("full_beat_held", 32'(mem_enable), 32'd1);
      mem_busy = 1'b0;
      for (int i = 17; i <= 20; i++) push_word(32'h0000_0300 + 32'(i), (i == 20), 20);
      drain();
      check_finished("overflow", 32'd20);

      // Reset lands in the middle of a burst, then a fresh session
      start_session();
      for (int i = 1; i <= 4; i++) push_word(32'h0000_0400 + 32'(i), 1'b0, 4);
      wait_commits(2);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      sb_q.delete();
      tick();
      reset = 1'b0;
      tick();
      start_session();
      for (int i = 1; i <= 4; i++) push_word(32'h0000_0500 + 32'(i), (i == 4), 4);
      drain();
      check_finished("after_reset", 32'd4);

      // Single-word image, then a second session from DONE
      start_session();
      push_word(32'hDEAD_BEEF, 1'b1, 1);
      drain();
      check_finished("single_word", 32'd1);
      start_session();
      check("second_start_done", 32'(done), 32'd0);
      check("second_start_fetch", 32'(enable_fetch), 32'd0);
      check("second_start_words", words_written, 32'd0);
      push_word(32'h1234_5678, 1'b1, 1);
      drain();
      check_finished("second_single", 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
